// File: rtl/vga_sync_pkg.sv
// vga_sync_pkg: shared 640x480@60 raster timing, counter width and colour constants.
package vga_sync_pkg;
    localparam int CNT_W = 10;
    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP = 29;
    localparam int DEF_V_ACTIVE = 480;
    localparam bit DEF_SYNC_POL = 1'b0;
    localparam int DEF_H_TOTAL = DEF_H_FP + DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE;
    localparam int DEF_V_TOTAL = DEF_V_FP + DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;
    typedef logic [CNT_W-1:0] cnt_t;
    function automatic logic in_span(input cnt_t v, input int lo, input int hi);
        return (v >= cnt_t'(lo)) && (v <= cnt_t'(hi));
    endfunction
endpackage

// File: rtl/vga_mod_counter.sv
// vga_mod_counter: modulo-MOD counter advancing on inc, exposing its next value and wrap.
module vga_mod_counter
    import vga_sync_pkg::*;
#(
    parameter int MOD = 800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] next,
    output logic             wrap
);
    logic [CNT_W-1:0] r_count;
    assign wrap = inc && (r_count == CNT_W'(MOD - 1));
    assign next = wrap ? '0 : (inc ? r_count + 1'b1 : r_count);
    assign count = r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else r_count <= next;
    end
endmodule

// File: rtl/vga_sync.sv
// vga_sync: pixel-rate divider, h/v raster counters and registered sync/bright/frame_start.
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start
);
    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
    logic             r_pix_tick, r_hsync, r_vsync, r_bright, r_frame_start;
    logic             w_h_wrap, w_v_wrap;
    logic [CNT_W-1:0] w_h_nxt, w_v_nxt;
    assign w_div_nxt = (r_div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : r_div_cnt + 1'b1;
    vga_mod_counter #(.MOD(H_TOTAL)) u_h (
        .clk(clk), .rst_n(rst_n), .inc(r_pix_tick),
        .count(h_count), .next(w_h_nxt), .wrap(w_h_wrap)
    );
    vga_mod_counter #(.MOD(V_TOTAL)) u_v (
        .clk(clk), .rst_n(rst_n), .inc(w_h_wrap),
        .count(v_count), .next(w_v_nxt), .wrap(w_v_wrap)
    );
    // Outputs are computed from next-state counters so they land on the same edge as the counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_pix_tick    <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_bright      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_nxt;
            r_pix_tick    <= (w_div_nxt == DIV_W'(CLK_DIV - 1));
            r_hsync       <= in_span(w_h_nxt, H_FP, H_FP + H_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= in_span(w_v_nxt, V_FP, V_FP + V_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
            r_bright      <= (w_h_nxt >= CNT_W'(H_TOTAL - H_ACTIVE)) && (w_v_nxt >= CNT_W'(V_TOTAL - V_ACTIVE));
            r_frame_start <= w_v_wrap;
        end
    end
    assign pix_tick = r_pix_tick;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign bright = r_bright;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of the default raster plus a tiny fast raster for frame wrap.
module tb_vga_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n2 = 1'b0;
    logic [9:0] h, v, h2, v2;
    logic br, hs, vs, pt, fs, br2, hs2, vs2, pt2, fs2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_sync dut (
        .clk(clk), .rst_n(rst_n), .h_count(h), .v_count(v), .bright(br),
        .hsync(hs), .vsync(vs), .pix_tick(pt), .frame_start(fs)
    );

    // 12 x 7 raster, one pixel per clock, active-high syncs: a frame is 84 clocks.
    vga_sync #(
        .CLK_DIV(1), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_ACTIVE(5),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .V_ACTIVE(3), .SYNC_POL(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n2), .h_count(h2), .v_count(v2), .bright(br2),
        .hsync(hs2), .vsync(vs2), .pix_tick(pt2), .frame_start(fs2)
    );

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (h !== 10'd0 || v !== 10'd0) begin
            failures++;
            $display("FAIL reset_counts got h=%0d v=%0d exp h=0 v=0", h, v);
        end
        checks++;
        if ({hs, vs} !== 2'b11) begin
            failures++;
            $display("FAIL reset_syncs got hs=%b vs=%b exp 1 1", hs, vs);
        end
        checks++;
        if ({br, pt, fs} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got br=%b pt=%b fs=%b exp 0 0 0", br, pt, fs);
        end
        for (int k = 1; k <= 6; k++) begin
            step;
            checks++;
            if (pt !== 1'(k % 2) || h !== 10'(k / 2) || v !== 10'd0) begin
                failures++;
                $display("FAIL tick_seq k=%0d got pt=%b h=%0d v=%0d exp pt=%0d h=%0d v=0", k, pt, h, v, k % 2, k / 2);
            end
        end
    endtask

    task automatic test_line;
        int low = 0, first = -1, last = -1, fs_hi = 0;
        do_reset;
        for (int k = 0; k <= 1600; k++) begin
            if (hs === 1'b0) begin
                low++;
                if (first < 0) first = k;
                last = k;
            end
            if (fs !== 1'b0) fs_hi++;
            if (k == 1599) begin
                checks++;
                if (h !== 10'd799 || v !== 10'd0) begin
                    failures++;
                    $display("FAIL line_end got h=%0d v=%0d exp h=799 v=0", h, v);
                end
            end
            if (k == 1600) begin
                checks++;
                if (h !== 10'd0 || v !== 10'd1) begin
                    failures++;
                    $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", h, v);
                end
            end
            if (k < 1600) step;
        end
        checks++;
        if (low != 192) begin
            failures++;
            $display("FAIL hsync_width got %0d clks exp 192", low);
        end
        checks++;
        if (first != 32 || last != 223) begin
            failures++;
            $display("FAIL hsync_window got first=%0d last=%0d exp 32 223", first, last);
        end
        checks++;
        if (fs_hi != 0) begin
            failures++;
            $display("FAIL fs_quiet got %0d pulses exp 0", fs_hi);
        end
    endtask

    task automatic test_regions;
        int vlow = 0, vfirst = -1, bfirst = -1;
        do_reset;
        for (int k = 0; k <= 65921; k++) begin
            if (vs === 1'b0) begin
                vlow++;
                if (vfirst < 0) vfirst = k;
            end
            if (br === 1'b1 && bfirst < 0) bfirst = k;
            if (k == 65598) begin
                checks++;
                if (h !== 10'd799 || v !== 10'd40 || br !== 1'b0) begin
                    failures++;
                    $display("FAIL bright_799_40 got h=%0d v=%0d br=%b exp 799 40 0", h, v, br);
                end
            end
            if (k == 65918) begin
                checks++;
                if (h !== 10'd159 || v !== 10'd41 || br !== 1'b0) begin
                    failures++;
                    $display("FAIL bright_159_41 got h=%0d v=%0d br=%b exp 159 41 0", h, v, br);
                end
            end
            if (k == 65920) begin
                checks++;
                if (h !== 10'd160 || v !== 10'd41 || br !== 1'b1) begin
                    failures++;
                    $display("FAIL bright_160_41 got h=%0d v=%0d br=%b exp 160 41 1", h, v, br);
                end
            end
            if (k < 65921) step;
        end
        checks++;
        if (vlow != 3200 || vfirst != 16000) begin
            failures++;
            $display("FAIL vsync_window got clks=%0d first=%0d exp 3200 16000", vlow, vfirst);
        end
        checks++;
        if (bfirst != 65920) begin
            failures++;
            $display("FAIL bright_first got %0d exp 65920", bfirst);
        end
    endtask

    task automatic test_reset_mid;
        checks++;
        if (pt !== 1'b1 || h !== 10'd160) begin
            failures++;
            $display("FAIL mid_precond got pt=%b h=%0d exp 1 160", pt, h);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (h !== 10'd0 || v !== 10'd0 || {hs, vs, br, pt, fs} !== 5'b11000) begin
            failures++;
            $display("FAIL async_reset got h=%0d v=%0d hs=%b vs=%b br=%b pt=%b fs=%b exp 0 0 1 1 0 0 0", h, v, hs, vs, br, pt, fs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step;
        checks++;
        if (h !== 10'd0 || pt !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_1 got h=%0d pt=%b exp 0 1", h, pt);
        end
        step;
        checks++;
        if (h !== 10'd1 || v !== 10'd0 || pt !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_2 got h=%0d v=%0d pt=%b exp 1 0 0", h, v, pt);
        end
    endtask

    task automatic test_fast;
        int tick_err = 0, hs_hi = 0, vs_hi = 0, fs_cnt = 0, fs_first = -1, fs_last = -1;
        @(negedge clk);
        rst_n2 = 1'b1;
        #1;
        for (int k = 0; k <= 170; k++) begin
            if (k >= 1 && pt2 !== 1'b1) tick_err++;
            if (k == 0 && pt2 !== 1'b0) tick_err++;
            if (k >= 1 && k <= 84 && hs2 === 1'b1) hs_hi++;
            if (k >= 1 && k <= 84 && vs2 === 1'b1) vs_hi++;
            if (fs2 === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                fs_last = k;
            end
            if (k == 84) begin
                checks++;
                if (h2 !== 10'd11 || v2 !== 10'd6 || br2 !== 1'b1) begin
                    failures++;
                    $display("FAIL fast_last_pixel got h=%0d v=%0d br=%b exp 11 6 1", h2, v2, br2);
                end
            end
            if (k == 85) begin
                checks++;
                if (h2 !== 10'd0 || v2 !== 10'd0 || br2 !== 1'b0 || fs2 !== 1'b1) begin
                    failures++;
                    $display("FAIL fast_wrap got h=%0d v=%0d br=%b fs=%b exp 0 0 0 1", h2, v2, br2, fs2);
                end
            end
            if (k < 170) step;
        end
        checks++;
        if (tick_err != 0) begin
            failures++;
            $display("FAIL fast_tick got %0d bad samples exp 0", tick_err);
        end
        checks++;
        if (hs_hi != 21 || vs_hi != 24) begin
            failures++;
            $display("FAIL fast_syncs got hs=%0d vs=%0d exp 21 24", hs_hi, vs_hi);
        end
        checks++;
        if (fs_cnt != 2 || fs_first != 85 || fs_last != 169) begin
            failures++;
            $display("FAIL fast_frame_start got n=%0d first=%0d last=%0d exp 2 85 169", fs_cnt, fs_first, fs_last);
        end
    endtask

    initial begin
        test_reset;
        test_line;
        test_regions;
        test_reset_mid;
        test_fast;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Upstream timing generator for the VGA image stage.
- Divides the system clock to a pixel rate and runs horizontal/vertical pixel counters over a 640x480 @ 60 Hz raster (800 x 521 total).
- Drives hsync/vsync to the connector.
- Supplies h_count, v_count and bright to the downstream colour generator, which converts them to 3-bit rgb.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1); 50 MHz in gives 25 MHz pixel rate
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_ACTIVE, 640, visible pixels per line
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 29, vertical back porch in lines
- V_ACTIVE, 480, visible lines per frame
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- h_count  out  10  pixel index in line, 0..H_TOTAL-1
- v_count  out  10  line index in frame, 0..V_TOTAL-1
- bright  out  1  high while (h_count, v_count) is in the visible region
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- pix_tick  out  1  one-clk pulse; counters advance on the next edge
- frame_start  out  1  one-clk pulse on the first clk cycle with h_count=0, v_count=0

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low; all flops clear immediately on rst_n=0, release is synchronous to clk.
- Derived constants: H_TOTAL = H_FP+H_SYNC+H_BP+H_ACTIVE (800); V_TOTAL = V_FP+V_SYNC+V_BP+V_ACTIVE (521).
- Line layout (h): FP 0..H_FP-1, sync H_FP..H_FP+H_SYNC-1 (16..111), BP 112..159, active H_TOTAL-H_ACTIVE..H_TOTAL-1 (160..799).
- Frame layout (v): FP 0..9, sync 10..11, BP 12..40, active 41..520.
- Reset values:
  - div_cnt=0, h_count=0, v_count=0
  - hsync=vsync=~SYNC_POL
  - bright=0, pix_tick=0, frame_start=0
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick=1 exactly when div_cnt==CLK_DIV-1; with CLK_DIV=1, pix_tick is constantly 1 out of reset.
- Counters, updated on each clk edge where pix_tick=1:
  - h_count==H_TOTAL-1 → h_count=0 and v_count advances; otherwise h_count+1.
  - v_count advances as: v_count==V_TOTAL-1 → 0, else +1.
  - No state change when pix_tick=0.
- Registered outputs:
  - hsync, vsync and bright are registered from the next-state counter values, so they change on the same edge as h_count/v_count. No skew: every output is a pure function of the current (h_count, v_count).
  - hsync = SYNC_POL when 16 <= h_count <= 111, else ~SYNC_POL.
  - vsync = SYNC_POL when 10 <= v_count <= 11, else ~SYNC_POL.
  - bright = (h_count >= 160) && (v_count >= 41).
  - The downstream stage's frame window (h 170..790, v 51..511) always lies inside bright.
- frame_start:
  - Registered; 1 for exactly one clk cycle, the first cycle after the counters move to (0,0).
  - Not asserted on the cycle after reset release.
- Wrap-around: the h and v wrap coincide on the last pixel of the frame → next state is (0,0) in one edge.
- Widths: 10 bits is sufficient (max 799 / 520); no overflow path exists.
- Reset mid-frame: all outputs return to reset values asynchronously; counting restarts from (0,0) with a full CLK_DIV period before the first tick.

Decomposition:
- Shared include vga_timing.vh: the eight timing defaults, H_TOTAL/V_TOTAL, colour constants (BLACK/RED/WHITE). Shared with the display stage so region boundaries are defined once.
- One natural sub-module: vga_mod_counter (parameter MOD; inputs clk, rst_n, inc; outputs count, wrap), instantiated once for h and once for v, with h.wrap gating v.inc.

Test Plan:
- Reset release, CLK_DIV=2 → pix_tick high every 2nd clk. h_count goes 0,0,1,1,2… per clk; v_count=0; hsync=1, vsync=1, bright=0.
- Run one line → hsync=0 exactly while h_count 16..111, i.e. 96 pixels = 192 clks. Wrap 799→0 increments v_count 0→1 on the same edge.
- Run to v_count=41, h_count=160 → bright rises on that edge. bright=0 at (159,41) and (799,40); bright=1 at (799,520).
- Full frame → vsync=0 for lines 10..11 only (1600 pixel ticks). (799,520)→(0,0) after 416800 ticks = 833600 clks; frame_start is a single-clk pulse then, and every 833600 clks after.
- Assert rst_n low at (400,300) mid-tick → outputs immediately at reset values. After release, first advance occurs 2 clks later to (1,0).
- CLK_DIV=1, SYNC_POL=1 → pix_tick constant 1, hsync high for h 16..111, and a frame takes 416800 clks.
